// File: rtl/pc_seq_pkg.sv
// Shared processor definitions: FSM state encodings and opcode values
// used by the program-counter sequencer and its return stack.
package pc_seq_pkg;

  // Sequencer states; outputs are decoded directly from these.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Opcode field width on the op port.
  localparam int unsigned OP_W = 3;

  // Operation codes; the two reserved codes execute as NOP.
  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BZ   = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HALT = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  // Width of an occupancy counter able to hold 0..sd inclusive.
  function automatic int unsigned cnt_w(input int unsigned sd);
    return $clog2(sd) + 1;
  endfunction

endpackage

// File: rtl/pc_seq_ret_stack.sv
// LIFO of return addresses for CALL/RET. Push has priority over pop if
// both are requested; a push while full or a pop while empty is ignored,
// so the caller decides how to report those cases.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int AW = 8,
  parameter int SD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [AW-1:0]        push_data,
  output logic [AW-1:0]        top,
  output logic [cnt_w(SD)-1:0] depth,
  output logic                 full,
  output logic                 empty
);

  localparam int DW = cnt_w(SD);
  localparam int IW = (SD > 1) ? $clog2(SD) : 1;

  logic [AW-1:0] r_mem [SD];
  logic [DW-1:0] r_depth;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_top_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_depth == DW'(SD));
  assign empty     = (r_depth == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty & ~push;

  // Next free slot is at index depth; the newest entry sits just below it.
  assign w_wr_idx  = r_depth[IW-1:0];
  assign w_top_idx = r_depth[IW-1:0] - IW'(1);

  // Store the return address into the next free slot.
  // NOTE: the storage array has no reset; stale contents are harmless
  // because the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  // Track occupancy; cleared asynchronously so reset leaves an empty stack.
  // NOTE: state registers use non-blocking assignment so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  // An empty stack presents zero rather than whatever the array holds.
  assign top   = empty ? '0 : r_mem[w_top_idx];
  assign depth = r_depth;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer. Each instruction takes two clocks: FETCH
// presents pc to instruction memory, EXEC samples op/target/zero and
// commits the next pc (and any return-stack push/pop) on the edge that
// leaves EXEC. Overflow/underflow of the return stack sets a sticky flag
// that only reset clears.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int AW = 8,
  parameter int SD = 4
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 run,
  input  logic [OP_W-1:0]      op,
  input  logic [AW-1:0]        target,
  input  logic                 zero,
  output logic [AW-1:0]        pc,
  output logic                 fetch,
  output logic                 halted,
  output logic [cnt_w(SD)-1:0] depth,
  output logic                 stack_err
);

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_next;
  logic [AW-1:0] w_pc_inc;
  logic          r_stack_err;
  logic          w_err_set;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_top;
  logic          w_full;
  logic          w_empty;
  logic          w_exec;

  // Increment wraps naturally at AW bits; the same value is the return
  // address, so a CALL at all-ones pushes zero.
  assign w_pc_inc = r_pc + AW'(1);
  assign w_exec   = (r_state == ST_EXEC);

  ret_stack #(
    .AW (AW),
    .SD (SD)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (r),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_top),
    .depth     (depth),
    .full      (w_full),
    .empty     (w_empty)
  );

  // State register; reset forces IDLE without waiting for a clock.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; HALT in EXEC is the only path into HALTED.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (run) w_state_next = ST_FETCH;
      ST_FETCH:  w_state_next = ST_EXEC;
      ST_EXEC:   w_state_next = (op == OP_HALT) ? ST_HALTED : ST_FETCH;
      ST_HALTED: if (!run) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    fetch  = 1'b0;
    halted = 1'b0;
    unique case (r_state)
      ST_FETCH:  fetch  = 1'b1;
      ST_HALTED: halted = 1'b1;
      default:   ;
    endcase
  end

  // Instruction execute: next pc plus stack side effects, active in EXEC only.
  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (w_exec) begin
      case (op)
        OP_JMP:  w_pc_next = target;
        OP_BZ:   w_pc_next = zero ? target : w_pc_inc;
        OP_CALL: begin
          if (!w_full) begin
            w_push    = 1'b1;
            w_pc_next = target;
          end else begin
            w_pc_next = w_pc_inc;
            w_err_set = 1'b1;
          end
        end
        OP_RET: begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_pc_next = w_top;
          end else begin
            w_pc_next = w_pc_inc;
            w_err_set = 1'b1;
          end
        end
        OP_HALT: w_pc_next = r_pc;
        default: w_pc_next = w_pc_inc;
      endcase
    end
  end

  // Program counter: the sole source of the instruction-memory address.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_pc <= '0;
    end else if (w_exec) begin
      r_pc <= w_pc_next;
    end
  end

  // Sticky stack error; nothing but reset clears it.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_stack_err <= 1'b0;
    end else if (w_err_set) begin
      r_stack_err <= 1'b1;
    end
  end

  assign pc        = r_pc;
  assign stack_err = r_stack_err;

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter AW, default 8, program-counter and target width.
REQ-002 SHALL have parameter SD, default 4, return-stack depth in entries.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port r  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run  input  1  start request; level-sensitive.
REQ-006 SHALL have port op  input  3  operation code, sampled in EXEC: 0 NOP, 1 JMP, 2 BZ, 3 CALL, 4 RET, 5 HALT, 6-7 treated as NOP.
REQ-007 SHALL have port target  input  AW  jump/branch/call destination, sampled in EXEC.
REQ-008 SHALL have port zero  input  1  condition flag for BZ, sampled in EXEC.
REQ-009 SHALL have port pc  output  AW  current program counter (instruction address).
REQ-010 SHALL have port fetch  output  1  high while in FETCH; pc valid for instruction memory.
REQ-011 SHALL have port halted  output  1  high while in HALTED.
REQ-012 SHALL have port depth  output  clog2(SD)+1  number of occupied return-stack entries.
REQ-013 SHALL have port stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, EXEC, HALTED; outputs are Moore, decoded from registered state.
REQ-015 IDLE SHALL go to FETCH on posedge with run=1; otherwise stay in IDLE; pc holds.
REQ-016 FETCH SHALL go to EXEC unconditionally after exactly one cycle; pc holds.
REQ-017 EXEC SHALL update pc at the posedge that leaves EXEC, then enter FETCH, except on HALT.
REQ-018 NOP/undefined: pc <= pc+1.
REQ-019 JMP: pc <= target.
REQ-020 BZ: pc <= target if zero=1, else pc+1.
REQ-021 CALL with depth<SD: push pc+1, depth+1, pc <= target.
REQ-022 CALL with depth=SD: no push, pc <= pc+1, stack_err <= 1.
REQ-023 RET with depth>0: pc <= top entry, depth-1.
REQ-024 RET with depth=0: pc <= pc+1, stack_err <= 1.
REQ-025 HALT: pc holds, next state HALTED.
REQ-026 HALTED SHALL go to IDLE when run=0; pc, stack and stack_err hold.
REQ-027 pc+1 SHALL wrap modulo 2^AW (all-ones -> 0); no flag raised.
REQ-028 Pushed return address SHALL be truncated to AW bits (CALL at all-ones pushes 0).
REQ-029 stack_err SHALL clear only on reset.
REQ-030 Full cycle latency SHALL be 2 clocks per instruction (FETCH + EXEC).

Reset
REQ-031 r=0 SHALL immediately, without a clock edge, force state IDLE, pc=0, depth=0, stack_err=0, fetch=0, halted=0.
REQ-032 Reset mid-instruction SHALL discard the pending EXEC update; no push/pop commits.
REQ-033 Stack entry contents need not be reset; they SHALL be unreadable while depth=0.
REQ-034 After r rises, the first state change SHALL occur no earlier than the next posedge clk.

Structure
REQ-035 Opcode constants and FSM state encodings SHALL reside in the shared processor package.
REQ-036 Return stack SHALL be a sub-module ret_stack (push, pop, top, depth, full, empty).
REQ-037 pc SHALL be the only register driving the instruction-memory address.

Verification
REQ-038 r=0 pulse mid-EXEC with pc=0x12 -> pc=0, state IDLE, depth=0 before the next edge.
REQ-039 run=1, op=NOP repeated from pc=0xFE -> pc sequence FE, FF, 00, fetch toggling every cycle.
REQ-040 BZ target=0x40, zero=0 at pc=0x10 -> pc=0x11; zero=1 -> pc=0x40.
REQ-041 Five CALLs to 0x80 from pc=0x05 -> depth 1..4, fifth gives pc=0x81, stack_err=1, depth=4.
REQ-042 Four RETs after CALLs from 0x05,0x80,0x80,0x80 -> pc 0x81,0x81,0x81,0x06; fifth RET -> pc=0x07, stack_err=1.
REQ-043 HALT at pc=0x20 -> halted=1, pc=0x20 held; run=0 -> IDLE; run=1 -> FETCH at pc=0x20.
